i2c_apb_arbiter: RTL

Two-requester APB arbiter sharing the single APB slave port of the CoreI2C instance. It sits between two independent I2C transaction sequencers (e.g. the sensor poller and the telemetry writer) and the CoreI2C APB port. Each transfer is serialised through a registered SETUP/ACCESS sequence. A per-requester LOCK holds ownership across a whole START…STOP I2C transaction, and a watchdog frees a stale lock.

---
 rtl/i2c_apb_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_apb_arbiter.sv
// i2c_apb_arbiter
//   Shares the single CoreI2C APB slave port between two requesters. Each transfer runs as a
//   registered SETUP/ACCESS sequence followed by a one-cycle response to the winner. A requester
//   may hold ownership across a whole I2C transaction with its LOCK input, and a watchdog frees
//   a lock whose owner has gone quiet for TIMEOUT idle cycles.
//
// Ports
//   PCLK, PRESETN                   clock, asynchronous active-low reset
//   Mx_PSEL/PENABLE/PWRITE/PADDR/PWDATA/LOCK   requester x APB request and lock hint
//   Mx_PRDATA/PREADY/PSLVERR        requester x response (PREADY high one cycle)
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB master side towards CoreI2C
//   PRDATA/PREADY/PSLVERR           CoreI2C response
//   GNT                             one-hot current/last owner, 00 when none yet
//   LOCKED                          GNT owner holds the lock
//   LOCK_TO                         one-cycle pulse when the watchdog drops a lock

module i2c_apb_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       M0_PSEL,
  input  logic       M0_PENABLE,
  input  logic       M0_PWRITE,
  input  logic [8:0] M0_PADDR,
  input  logic [7:0] M0_PWDATA,
  input  logic       M0_LOCK,
  output logic [7:0] M0_PRDATA,
  output logic       M0_PREADY,
  output logic       M0_PSLVERR,
  input  logic       M1_PSEL,
  input  logic       M1_PENABLE,
  input  logic       M1_PWRITE,
  input  logic [8:0] M1_PADDR,
  input  logic [7:0] M1_PWDATA,
  input  logic       M1_LOCK,
  output logic [7:0] M1_PRDATA,
  output logic       M1_PREADY,
  output logic       M1_PSLVERR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [8:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  output logic [1:0] GNT,
  output logic       LOCKED,
  output logic       LOCK_TO
);

  localparam logic [15:0] ToLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  // One-hot record of the last completed grant; a tie goes to the other requester.
  // Reset value 01 makes the first contended grant go to requester 1.
  logic [1:0]  last_q, last_d;
  logic        locked_q, locked_d;
  logic        lock_to_q, lock_to_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        pwrite_q, pwrite_d;
  logic [8:0]  paddr_q, paddr_d;
  logic [7:0]  pwdata_q, pwdata_d;
  logic [7:0]  m0_prdata_q, m0_prdata_d, m1_prdata_q, m1_prdata_d;
  logic        m0_pslverr_q, m0_pslverr_d, m1_pslverr_q, m1_pslverr_d;

  logic [1:0]  elig;
  logic [1:0]  win;
  logic        owner_psel;
  logic        owner_lock;

  // Requesters' PENABLE carries no information the arbiter needs.
  logic unused_penable;
  assign unused_penable = M0_PENABLE ^ M1_PENABLE;

  always_comb begin
    owner_psel = |(gnt_q & {M1_PSEL, M0_PSEL});
    owner_lock = |(gnt_q & {M1_LOCK, M0_LOCK});
    elig[0]    = M0_PSEL & (~locked_q | gnt_q[0]);
    elig[1]    = M1_PSEL & (~locked_q | gnt_q[1]);
    win        = (&elig) ? ~last_q : elig;
  end

  // State register
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath / bookkeeping registers
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      gnt_q        <= 2'b00;
      last_q       <= 2'b01;
      locked_q     <= 1'b0;
      lock_to_q    <= 1'b0;
      wd_cnt_q     <= '0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      m0_prdata_q  <= '0;
      m1_prdata_q  <= '0;
      m0_pslverr_q <= 1'b0;
      m1_pslverr_q <= 1'b0;
    end else begin
      gnt_q        <= gnt_d;
      last_q       <= last_d;
      locked_q     <= locked_d;
      lock_to_q    <= lock_to_d;
      wd_cnt_q     <= wd_cnt_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      m0_prdata_q  <= m0_prdata_d;
      m1_prdata_q  <= m1_prdata_d;
      m0_pslverr_q <= m0_pslverr_d;
      m1_pslverr_q <= m1_pslverr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_d       = last_q;
    locked_d     = locked_q;
    lock_to_d    = 1'b0;
    wd_cnt_d     = '0;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    m0_prdata_d  = m0_prdata_q;
    m1_prdata_d  = m1_prdata_q;
    m0_pslverr_d = m0_pslverr_q;
    m1_pslverr_d = m1_pslverr_q;

    unique case (state_q)
      StIdle: begin
        if (|elig) begin
          // An owner request always beats a pending watchdog expiry.
          state_d  = StSetup;
          gnt_d    = win;
          pwrite_d = win[1] ? M1_PWRITE : M0_PWRITE;
          paddr_d  = win[1] ? M1_PADDR  : M0_PADDR;
          pwdata_d = win[1] ? M1_PWDATA : M0_PWDATA;
        end else if (locked_q) begin
          // Nothing eligible while locked implies the owner is not selecting.
          if (!owner_lock) begin
            locked_d = 1'b0;
          end else if (wd_cnt_q == ToLast) begin
            locked_d  = 1'b0;
            lock_to_d = 1'b1;
          end else begin
            wd_cnt_d = wd_cnt_q + 16'd1;
          end
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (PREADY) begin
          state_d = StResp;
          if (gnt_q[0]) begin
            m0_prdata_d  = PRDATA;
            m0_pslverr_d = PSLVERR;
          end
          if (gnt_q[1]) begin
            m1_prdata_d  = PRDATA;
            m1_pslverr_d = PSLVERR;
          end
        end
      end
      StResp: begin
        state_d  = StIdle;
        last_d   = gnt_q;
        locked_d = owner_lock;
      end
    endcase
  end

  // Outputs
  always_comb begin
    PSEL      = (state_q == StSetup) || (state_q == StAccess);
    PENABLE   = (state_q == StAccess);
    M0_PREADY = (state_q == StResp) && gnt_q[0];
    M1_PREADY = (state_q == StResp) && gnt_q[1];
  end

  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign M0_PRDATA  = m0_prdata_q;
  assign M1_PRDATA  = m1_prdata_q;
  assign M0_PSLVERR = m0_pslverr_q;
  assign M1_PSLVERR = m1_pslverr_q;
  assign GNT        = gnt_q;
  assign LOCKED     = locked_q;
  assign LOCK_TO    = lock_to_q;

endmodule
